// File: rtl/store_pkg.sv
// Shared constants and state encoding for the store-path write formatter.
package store_pkg;

  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    BEAT0,
    BEAT1
  } state_e;

endpackage

// File: rtl/store_lane_gen.sv
// Combinational lane generator: turns a store encoding, byte offset and rs2 value into a
// two-word byte mask and lane-aligned data. The upper word is non-zero only for stores
// that cross a word boundary.
module store_lane_gen
  import store_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned Lanes = WIDTH / 8,
  localparam int unsigned OffW = $clog2(Lanes)
) (
  input  logic [6:0]         opcode,
  input  logic [2:0]         funct3,
  input  logic [OffW-1:0]    off,
  input  logic [WIDTH-1:0]   data,
  output logic [2*Lanes-1:0] mask,
  output logic [2*WIDTH-1:0] wdata,
  output logic               legal
);

  logic [Lanes-1:0] size_mask;
  logic [WIDTH-1:0] data_kept;

  // Decode access size, keep only the stored bytes, then shift both into lane position.
  always_comb begin
    size_mask = '0;
    legal     = 1'b0;
    case (funct3)
      F3_SB: begin
        size_mask = Lanes'(1);
        legal     = (opcode == OPC_STORE);
      end
      F3_SH: begin
        size_mask = Lanes'(3);
        legal     = (opcode == OPC_STORE);
      end
      F3_SW: begin
        size_mask = '1;
        legal     = (opcode == OPC_STORE);
      end
      default: begin
        size_mask = '0;
        legal     = 1'b0;
      end
    endcase

    for (int i = 0; i < Lanes; i++) begin
      data_kept[8*i +: 8] = size_mask[i] ? data[8*i +: 8] : 8'h00;
    end

    mask  = {{Lanes{1'b0}}, size_mask} << off;
    wdata = {{WIDTH{1'b0}}, data_kept} << {off, 3'b000};
  end

endmodule

// File: rtl/store_align.sv
// Store-path write formatter: accepts one store per handshake, aligns rs2 data into byte
// lanes and writes it through a word-addressed req/ack port, splitting misaligned stores
// into two aligned beats. done/err are registered one-cycle pulses.
module store_align
  import store_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned Lanes = WIDTH / 8,
  localparam int unsigned OffW = $clog2(Lanes)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] inst,
  input  logic [WIDTH-1:0] addr,
  input  logic [WIDTH-1:0] data,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic [Lanes-1:0] mem_be,
  input  logic             mem_ack,
  output logic             done,
  output logic             err
);

  state_e state_q, state_d;

  // Current beat drives the memory port directly; the second beat waits in hi_*.
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [Lanes-1:0] be_q, be_d;
  logic [WIDTH-1:0] hi_wdata_q, hi_wdata_d;
  logic [Lanes-1:0] hi_be_q, hi_be_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [2*Lanes-1:0] gen_mask;
  logic [2*WIDTH-1:0] gen_wdata;
  logic               gen_legal;

  // Only opcode and funct3 matter for a store.
  logic unused_inst;
  assign unused_inst = ^{inst[WIDTH-1:15], inst[11:7]};

  store_lane_gen #(
    .WIDTH(WIDTH)
  ) u_lane_gen (
    .opcode(inst[6:0]),
    .funct3(inst[14:12]),
    .off   (addr[OffW-1:0]),
    .data  (data),
    .mask  (gen_mask),
    .wdata (gen_wdata),
    .legal (gen_legal)
  );

  // State and beat registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      hi_wdata_q <= '0;
      hi_be_q    <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      hi_wdata_q <= hi_wdata_d;
      hi_be_q    <= hi_be_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic: accept in IDLE, advance a beat on each ack.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    hi_wdata_d = hi_wdata_q;
    hi_be_d    = hi_be_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (gen_legal) begin
            state_d    = BEAT0;
            addr_d     = {addr[WIDTH-1:OffW], {OffW{1'b0}}};
            be_d       = gen_mask[Lanes-1:0];
            wdata_d    = gen_wdata[WIDTH-1:0];
            hi_be_d    = gen_mask[2*Lanes-1:Lanes];
            hi_wdata_d = gen_wdata[2*WIDTH-1:WIDTH];
          end else begin
            err_d = 1'b1;
          end
        end
      end
      BEAT0: begin
        if (mem_ack) begin
          if (|hi_be_q) begin
            // Next word wraps naturally at the top of the address space.
            state_d = BEAT1;
            addr_d  = addr_q + WIDTH'(Lanes);
            be_d    = hi_be_q;
            wdata_d = hi_wdata_q;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      BEAT1: begin
        if (mem_ack) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = (state_q == IDLE) && !reset;
  assign mem_req   = (state_q != IDLE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
